// File: rtl/keeper_control_if.sv
// VGA stream bundle: pixel timing plus 12-bit rgb, one instance per chain hop.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/keeper_control.sv
// Goalkeeper-side round controller: keeper positioning, shot capture,
// SAVE/GOAL/MISS judgement and keeper/shot overlay on the VGA stream.
package game_pkg;
  typedef enum logic [1:0] {
    GS_START   = 2'd0,
    GS_SHOOTER = 2'd1,
    KEEPER     = 2'd2,
    GS_OVER    = 2'd3
  } g_state;
endpackage

module keeper_control #(
  parameter int GK_WIDTH    = 200,
  parameter int GK_HEIGHT   = 300,
  parameter int GK_POS_Y    = 250,
  parameter int GOAL_X_MIN  = 112,
  parameter int GOAL_X_MAX  = 911,
  parameter int GOAL_Y_MIN  = 150,
  parameter int GOAL_Y_MAX  = 600,
  parameter int POS_TIMEOUT = 32500000,
  parameter int SHOW_CYCLES = 13003901
) (
  input  logic            clk,
  input  logic            rst,
  input  game_pkg::g_state game_state,
  input  logic [11:0]     xpos,
  input  logic            left_clicked,
  input  logic [11:0]     shot_x,
  input  logic [11:0]     shot_y,
  input  logic            shot_valid,
  output logic            shot_ack,
  output logic            is_scored,
  output logic            round_done,
  output logic            end_gk,
  vga_if.in               in,
  vga_if.out              out
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ENGAGE    = 4'd1,
    S_POSITION  = 4'd2,
    S_WAIT_SHOT = 4'd3,
    S_RESULT    = 4'd4,
    S_SAVED     = 4'd5,
    S_CONCEDED  = 4'd6,
    S_MISSED    = 4'd7,
    S_TERMINATE = 4'd8
  } state_t;

  localparam logic [25:0]        POS_LAST  = 26'(POS_TIMEOUT - 1);
  localparam logic [25:0]        SHOW_LAST = 26'(SHOW_CYCLES - 1);
  localparam logic signed [12:0] HALF_W    = 13'(GK_WIDTH / 2);
  localparam logic signed [12:0] X_LO      = 13'(GOAL_X_MIN);
  localparam logic signed [12:0] X_HI      = 13'(GOAL_X_MAX - GK_WIDTH);
  localparam logic [11:0]        GK_X_RST  = 12'(GOAL_X_MIN);

  state_t             state;
  state_t             state_next;
  logic [25:0]        counter;
  logic [11:0]        gk_x;
  logic [11:0]        gk_target;
  logic [11:0]        shot_x_q;
  logic [11:0]        shot_y_q;
  logic               is_keeper;
  logic               in_display;
  logic signed [12:0] x_off;
  logic [12:0]        sx_e;
  logic [12:0]        sy_e;
  logic [12:0]        gk_e;
  logic [12:0]        h_e;
  logic [12:0]        v_e;
  logic               in_keeper;
  logic               in_goal;
  logic               box_hit;
  logic               mark_hit;
  logic [11:0]        pix_rgb;

  assign is_keeper  = (game_state == game_pkg::KEEPER);
  assign in_display = (state == S_SAVED) || (state == S_CONCEDED) || (state == S_MISSED);

  // Signed offset so a mouse position left of half the keeper width clamps low.
  assign x_off = $signed({1'b0, xpos}) - HALF_W;

  assign sx_e = {1'b0, shot_x_q};
  assign sy_e = {1'b0, shot_y_q};
  assign gk_e = {1'b0, gk_x};
  assign h_e  = {2'b00, in.hcount};
  assign v_e  = {2'b00, in.vcount};

  // Shot judgement, all bounds inclusive; keeper test wins over goal test.
  assign in_keeper = (sx_e >= gk_e) && (sx_e <= gk_e + 13'(GK_WIDTH)) &&
                     (sy_e >= 13'(GK_POS_Y)) && (sy_e <= 13'(GK_POS_Y + GK_HEIGHT));
  assign in_goal   = (sx_e >= 13'(GOAL_X_MIN)) && (sx_e <= 13'(GOAL_X_MAX)) &&
                     (sy_e >= 13'(GOAL_Y_MIN)) && (sy_e <= 13'(GOAL_Y_MAX));

  // Pixel hit tests against the keeper box and the 8x8 shot marker.
  assign box_hit  = (h_e >= gk_e) && (h_e <= gk_e + 13'(GK_WIDTH)) &&
                    (v_e >= 13'(GK_POS_Y)) && (v_e <= 13'(GK_POS_Y + GK_HEIGHT));
  assign mark_hit = (h_e >= sx_e) && (h_e <= sx_e + 13'd7) &&
                    (v_e >= sy_e) && (v_e <= sy_e + 13'd7);

  // Keeper x target: mouse centred on the box, clamped inside the goal mouth.
  always_comb begin
    gk_target = x_off[11:0];
    if (x_off < X_LO) begin
      gk_target = X_LO[11:0];
    end else if (x_off > X_HI) begin
      gk_target = X_HI[11:0];
    end else begin
      gk_target = x_off[11:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; leaving KEEPER aborts the round from any active state.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (is_keeper) state_next = S_ENGAGE;
        else           state_next = S_IDLE;
      end
      S_ENGAGE: begin
        if (is_keeper) state_next = S_POSITION;
        else           state_next = S_IDLE;
      end
      S_POSITION: begin
        if (!is_keeper)                             state_next = S_IDLE;
        else if (left_clicked || counter == POS_LAST) state_next = S_WAIT_SHOT;
        else                                        state_next = S_POSITION;
      end
      S_WAIT_SHOT: begin
        if (!is_keeper)     state_next = S_IDLE;
        else if (shot_valid) state_next = S_RESULT;
        else                 state_next = S_WAIT_SHOT;
      end
      S_RESULT: begin
        if (!is_keeper)    state_next = S_IDLE;
        else if (in_keeper) state_next = S_SAVED;
        else if (in_goal)   state_next = S_CONCEDED;
        else                state_next = S_MISSED;
      end
      S_SAVED, S_CONCEDED, S_MISSED: begin
        if (!is_keeper)               state_next = S_IDLE;
        else if (counter == SHOW_LAST) state_next = S_TERMINATE;
        else                          state_next = state;
      end
      S_TERMINATE: state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Round outputs decoded from the current state.
  always_comb begin
    shot_ack   = 1'b0;
    is_scored  = 1'b0;
    round_done = 1'b0;
    end_gk     = 1'b0;
    case (state)
      S_WAIT_SHOT: shot_ack = is_keeper && shot_valid;
      S_SAVED, S_MISSED: round_done = is_keeper && (counter == SHOW_LAST);
      S_CONCEDED: begin
        is_scored  = 1'b1;
        round_done = is_keeper && (counter == SHOW_LAST);
      end
      S_TERMINATE: end_gk = 1'b1;
      default: begin
        shot_ack   = 1'b0;
        is_scored  = 1'b0;
        round_done = 1'b0;
        end_gk     = 1'b0;
      end
    endcase
  end

  // Cycle counter: runs in POSITION and display states, cleared on every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= 26'd0;
    end else if (state_next != state) begin
      counter <= 26'd0;
    end else if (state == S_POSITION || in_display) begin
      counter <= counter + 26'd1;
    end else begin
      counter <= 26'd0;
    end
  end

  // Keeper follows the mouse while positioning and is frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      gk_x <= GK_X_RST;
    end else if (state == S_POSITION) begin
      gk_x <= gk_target;
    end else begin
      gk_x <= gk_x;
    end
  end

  // Capture the remote shot on the acknowledged cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shot_x_q <= 12'd0;
      shot_y_q <= 12'd0;
    end else if (state == S_WAIT_SHOT && is_keeper && shot_valid) begin
      shot_x_q <= shot_x;
      shot_y_q <= shot_y;
    end else begin
      shot_x_q <= shot_x_q;
      shot_y_q <= shot_y_q;
    end
  end

  // Overlay colour for the current input pixel; marker over keeper over background.
  always_comb begin
    pix_rgb = in.rgb;
    case (state)
      S_IDLE, S_ENGAGE, S_RESULT, S_TERMINATE: pix_rgb = in.rgb;
      S_POSITION, S_WAIT_SHOT: begin
        if (box_hit) pix_rgb = 12'h00F;
        else         pix_rgb = in.rgb;
      end
      S_SAVED, S_CONCEDED, S_MISSED: begin
        if (mark_hit) begin
          pix_rgb = 12'hFF0;
        end else if (box_hit) begin
          if (state == S_SAVED)         pix_rgb = 12'h0F0;
          else if (state == S_CONCEDED) pix_rgb = 12'hF00;
          else                          pix_rgb = 12'h888;
        end else begin
          pix_rgb = in.rgb;
        end
      end
      default: pix_rgb = 12'h00F;
    endcase
  end

  // VGA pipeline stage: timing forwarded and rgb overlaid with one cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= 11'd0;
      out.vcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'd0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_keeper_control.sv
// Randomised round-level bench for keeper_control with a behavioural model
// of keeper clamping, shot judgement, round timing and pixel overlay.
module tb_keeper_control;
  localparam int POS_T = 50;
  localparam int SHOW  = 20;

  logic             clk = 1'b0;
  logic             rst;
  game_pkg::g_state game_state;
  logic [11:0]      xpos, shot_x, shot_y;
  logic             left_clicked, shot_valid;
  logic             shot_ack, is_scored, round_done, end_gk;
  int               checks   = 0;
  int               failures = 0;

  vga_if vin();
  vga_if vout();

  keeper_control #(.POS_TIMEOUT(POS_T), .SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .xpos(xpos),
    .left_clicked(left_clicked), .shot_x(shot_x), .shot_y(shot_y),
    .shot_valid(shot_valid), .shot_ack(shot_ack), .is_scored(is_scored),
    .round_done(round_done), .end_gk(end_gk), .in(vin.in), .out(vout.out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_x(input int x);
    int v;
    v = x - 100;
    if (v < 112) return 112;
    if (v > 711) return 711;
    return v;
  endfunction

  // 0 = saved, 1 = conceded, 2 = missed
  function automatic int judge(input int gkx, input int sx, input int sy);
    if (sx >= gkx && sx <= gkx + 200 && sy >= 250 && sy <= 550) return 0;
    if (sx >= 112 && sx <= 911 && sy >= 150 && sy <= 600) return 1;
    return 2;
  endfunction

  // phase 0 = positioning/waiting, 1 = result display, 2 = no overlay
  function automatic logic [11:0] pix_exp(input int phase, input int outc, input int gkx,
                                          input int sx, input int sy, input int h, input int v,
                                          input logic [11:0] bg);
    bit box, mark;
    box  = (h >= gkx && h <= gkx + 200 && v >= 250 && v <= 550);
    mark = (h >= sx && h <= sx + 7 && v >= sy && v <= sy + 7);
    if (phase == 0) return box ? 12'h00F : bg;
    if (phase == 1) begin
      if (mark) return 12'hFF0;
      if (box) return (outc == 0) ? 12'h0F0 : (outc == 1) ? 12'hF00 : 12'h888;
      return bg;
    end
    return bg;
  endfunction

  task automatic set_pix(input int h, input int v, input logic [11:0] bg);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.rgb    = bg;
    vin.hsync  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_round(input int x, input int sx, input int sy, input bit click,
                          input bit early, input int dly, input int psel,
                          input bit abort_wait, input bit abort_disp, input int abort_at);
    int hoff[4] = '{-1, 0, 200, 201};
    int voff[4] = '{249, 250, 550, 551};
    int gkx, outc, lock_lat, exp_n, n, ph, pv, ph2, pv2;
    bit got, aborted;
    logic [11:0] bg, bg2;
    gkx  = clamp_x(x);
    outc = judge(gkx, sx, sy);
    xpos = 12'(x); shot_x = 12'(sx); shot_y = 12'(sy);
    left_clicked = 1'b0; shot_valid = 1'b0;
    game_state = game_pkg::KEEPER;
    tick(); tick();            // IDLE -> ENGAGE -> POSITION
    tick();                    // keeper now tracks the mouse
    if (psel >= 0) begin ph = gkx + hoff[psel]; pv = 250; end
    else begin ph = gkx + hoff[$urandom_range(0, 3)]; pv = voff[$urandom_range(0, 3)]; end
    bg = 12'($urandom);
    set_pix(ph, pv, bg);
    tick(); #2;
    chk("pos_pixel", vout.rgb, pix_exp(0, outc, gkx, sx, sy, ph, pv, bg));
    chk("pos_hcount", vout.hcount, ph);
    chk("pos_vcount", vout.vcount, pv);
    if (abort_wait) begin
      left_clicked = 1'b1;
      tick();                  // locked, waiting for the shot
      left_clicked = 1'b0;
      game_state = game_pkg::GS_START;
      #2 chk("abort_wait_ack", shot_ack, 1'b0);
      tick();
      shot_valid = 1'b1;
      for (int i = 0; i < 25; i++) begin
        #2 chk("abort_wait_outs", {shot_ack, is_scored, round_done, end_gk}, 4'b0000);
        tick();
      end
      shot_valid = 1'b0;
      tick();
      return;
    end
    lock_lat = click ? 1 : (POS_T - 2);
    exp_n    = early ? lock_lat : lock_lat + dly;
    got = 1'b0;
    n = 0;
    while (n < 200 && !got) begin
      if (n > 0) tick();
      left_clicked = click && (n == 0);
      shot_valid   = early || (n >= lock_lat + dly);
      #2;
      if (shot_ack === 1'b1) got = 1'b1;
      else n++;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    else      chk("ack_latency", n, exp_n);
    tick();                    // shot captured
    shot_valid = 1'b0; left_clicked = 1'b0;
    #2;
    chk("ack_pulse", shot_ack, 1'b0);
    chk("result_scored", is_scored, 1'b0);
    aborted = 1'b0;
    for (int c = 0; c < 22; c++) begin
      tick();
      if (c == 2) begin
        ph2 = sx + $urandom_range(0, 8); pv2 = sy + $urandom_range(0, 8);
        bg2 = 12'($urandom); set_pix(ph2, pv2, bg2);
      end
      if (c == 5) begin
        ph2 = gkx + 200 + $urandom_range(0, 1); pv2 = 550 + $urandom_range(0, 1);
        bg2 = 12'($urandom); set_pix(ph2, pv2, bg2);
      end
      if (c == 20) begin
        game_state = game_pkg::GS_START;
        ph2 = sx; pv2 = sy; bg2 = 12'($urandom); set_pix(ph2, pv2, bg2);
      end
      if (abort_disp && c == abort_at) game_state = game_pkg::GS_START;
      #2;
      if (c == 3 || c == 6) chk("disp_pixel", vout.rgb, pix_exp(1, outc, gkx, sx, sy, ph2, pv2, bg2));
      if (c == 21)          chk("term_pixel", vout.rgb, pix_exp(2, outc, gkx, sx, sy, ph2, pv2, bg2));
      if (aborted) begin
        chk("abort_disp_outs", {is_scored, round_done, end_gk}, 3'b000);
      end else if (abort_disp && c == abort_at) begin
        chk("abort_cycle_done", {round_done, end_gk}, 2'b00);
        aborted = 1'b1;
      end else begin
        chk("is_scored", is_scored, (c < SHOW && outc == 1) ? 1'b1 : 1'b0);
        chk("round_done", round_done, (c == SHOW - 1) ? 1'b1 : 1'b0);
        chk("end_gk", end_gk, (c == SHOW) ? 1'b1 : 1'b0);
      end
      chk("stray_ack", shot_ack, 1'b0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int gk, sx, sy;
    rst = 1'b1;
    game_state = game_pkg::KEEPER;
    xpos = 12'd500; shot_x = 12'd0; shot_y = 12'd0;
    left_clicked = 1'b1; shot_valid = 1'b1;
    vin.hcount = 11'd400; vin.vcount = 11'd250; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b1; vin.vblnk = 1'b1; vin.rgb = 12'hABC;
    tick(); tick(); tick();
    #2;
    chk("rst_outs", {shot_ack, is_scored, round_done, end_gk}, 4'b0000);
    chk("rst_hcount", vout.hcount, 11'd0);
    chk("rst_vcount", vout.vcount, 11'd0);
    chk("rst_sync", {vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 4'b0000);
    chk("rst_rgb", vout.rgb, 12'd0);
    game_state = game_pkg::GS_START; left_clicked = 1'b0; shot_valid = 1'b0;
    tick();
    rst = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    tick(); tick();
    #2 chk("idle_pass_rgb", vout.rgb, 12'hABC);

    // Directed rounds
    do_round(500, 520, 400, 1'b1, 1'b0, 2, 1, 1'b0, 1'b0, 0);   // saved, keeper pixel at (400,250)
    do_round(50, 150, 300, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0);    // low clamp, saved
    do_round(1000, 800, 300, 1'b1, 1'b0, 3, 2, 1'b0, 1'b0, 0);  // high clamp, saved
    do_round(500, 800, 300, 1'b1, 1'b0, 1, -1, 1'b0, 1'b0, 0);  // conceded
    do_round(500, 950, 300, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0, 0);  // missed, early shot_valid
    do_round(500, 600, 550, 0, 1'b1, 0, -1, 1'b0, 1'b0, 0);     // auto-lock, box corner saved
    do_round(500, 601, 550, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 0);  // one past keeper -> goal
    do_round(500, 911, 600, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 0);  // goal corner inclusive
    do_round(500, 912, 600, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 0);  // just outside goal
    do_round(500, 500, 601, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 0);  // below goal
    do_round(500, 400, 300, 1'b1, 1'b0, 0, -1, 1'b1, 1'b0, 0);  // abort while waiting
    do_round(500, 800, 300, 1'b1, 1'b0, 0, -1, 1'b0, 1'b1, 9);  // abort during conceded
    do_round(99, 112, 150, 0, 1'b0, 2, -1, 1'b0, 1'b0, 0);      // auto-lock, goal corner

    // Randomised rounds
    for (int r = 0; r < 16; r++) begin
      int x;
      x  = $urandom_range(0, 1100);
      gk = clamp_x(x);
      case ($urandom_range(0, 2))
        0:       begin sx = gk + $urandom_range(0, 201); sy = $urandom_range(248, 552); end
        1:       begin sx = $urandom_range(100, 925);    sy = $urandom_range(140, 610); end
        default: begin sx = $urandom_range(0, 1023);     sy = $urandom_range(0, 800);   end
      endcase
      do_round(x, sx, sy, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               $urandom_range(0, 4), -1, ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) == 0), $urandom_range(7, 18));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
